// File: rtl/dma_descriptor_issuer_if.sv
// dma_descriptor_issuer_if: queue-side and DCS-side signals of the descriptor issuer
interface dma_descriptor_issuer_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 8,
    parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH*112-1:0] QData;
    logic [NUM_CH-1:0] QEmpty;
    logic [NUM_CH-1:0] QPop;
    logic DcsChipSelect;
    logic DcsWrite;
    logic [ADDR_W-1:0] DcsAddress;
    logic [31:0] DcsWriteData;
    logic [3:0] DcsByteEnable;
    logic DcsRead;
    logic DcsWaitRequest;
    logic [31:0] DcsReadData;
    logic Busy;
    logic DescError;
    logic [CH_W-1:0] DescErrorCh;
    logic [NUM_CH*16-1:0] IssuedCount;
    modport master (
        input QData, QEmpty, DcsWaitRequest, DcsReadData,
        output QPop, DcsChipSelect, DcsWrite, DcsAddress, DcsWriteData, DcsByteEnable, DcsRead,
        output Busy, DescError, DescErrorCh, IssuedCount
    );
    modport slave (
        output QData, QEmpty, DcsWaitRequest, DcsReadData,
        input QPop, DcsChipSelect, DcsWrite, DcsAddress, DcsWriteData, DcsByteEnable, DcsRead,
        input Busy, DescError, DescErrorCh, IssuedCount
    );
endinterface

// File: rtl/dma_descriptor_issuer.sv
// dma_descriptor_issuer: round-robin queue arbiter turning entries into 5-word DCS descriptors (ISSUER_STATS_EN adds per-channel issued counters)
module dma_descriptor_issuer #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 8,
    parameter logic [63:0] STATUS_BASE = 64'h6000,
    parameter logic [63:0] STATUS_STRIDE = 64'h1000
) (
    input logic clock,
    input logic reset,
    dma_descriptor_issuer_if.master bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    state_t state, state_n;
    logic [CH_W-1:0] last_grant, grant, cand, chan, err_ch;
    logic [2:0] word;
    logic [111:0] entry, head;
    logic found, take, accept, last_ok, issuing;
    logic [63:0] status;
    logic unused_bits;

    // round-robin search starting just after the last granted channel
    always_comb begin
        grant = last_grant;
        cand = last_grant;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((int'(last_grant) + i) % NUM_CH);
            if (!found && !bus.QEmpty[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    assign head = bus.QData[int'(grant)*112 +: 112];
    assign take = (state == IDLE) && found && !reset;
    assign issuing = (state == ISSUE);
    assign accept = issuing && !bus.DcsWaitRequest;
    assign last_ok = accept && (word == 3'd4);

    // next state: a grant goes to ISSUE or straight to GAP when the entry is empty
    always_comb begin
        state_n = state;
        if (take)
            state_n = (head[107:105] == 3'd0) ? GAP : ISSUE;
        else if (last_ok)
            state_n = GAP;
        else if (state == GAP)
            state_n = IDLE;
    end

    // state, grant pointer, latched entry and word index
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            last_grant <= CH_W'(NUM_CH - 1);
            chan <= '0;
            err_ch <= '0;
            word <= '0;
            entry <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                last_grant <= grant;
                chan <= grant;
                entry <= head;
                word <= '0;
                if (head[107:105] == 3'd0)
                    err_ch <= grant;
            end else if (accept) begin
                word <= word + 3'd1;
            end
        end
    end

    assign status = STATUS_BASE + 64'(chan) * STATUS_STRIDE;
    assign bus.QPop = take ? (NUM_CH'(1) << grant) : '0;
    assign bus.DcsWrite = issuing;
    assign bus.DcsChipSelect = issuing;
    assign bus.Busy = issuing;
    assign bus.DcsRead = 1'b0;
    assign bus.DcsByteEnable = issuing ? 4'hF : 4'h0;
    assign bus.DcsAddress = issuing ? ADDR_W'({chan, word, 2'b00}) : '0;
    assign bus.DcsWriteData = !issuing ? 32'd0 :
                              (word == 3'd0) ? {29'd0, entry[107:105] - 3'd1} :
                              (word == 3'd1) ? entry[63:32] :
                              (word == 3'd2) ? entry[31:0] :
                              (word == 3'd3) ? status[63:32] : status[31:0];
    assign bus.DescError = take && (head[107:105] == 3'd0);
    assign bus.DescErrorCh = err_ch;
    assign unused_bits = ^{bus.DcsReadData, entry[111:108], entry[104:64]};

`ifdef ISSUER_STATS_EN
    logic [15:0] cnt [NUM_CH];

    // saturating count of completed descriptors per channel
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset)
                cnt[i] <= '0;
            else if (last_ok && int'(chan) == i && cnt[i] != 16'hFFFF)
                cnt[i] <= cnt[i] + 16'd1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
        assign bus.IssuedCount[c*16 +: 16] = cnt[c];
    end
`else
    assign bus.IssuedCount = '0;
`endif
endmodule

// File: tb/tb_dma_descriptor_issuer.sv
// tb_dma_descriptor_issuer: randomized scoreboard bench for dma_descriptor_issuer
module tb_dma_descriptor_issuer;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 8;
    localparam int CH_W = 1;
`ifdef ISSUER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct { int ch; logic [111:0] e; } push_t;
    typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dma_descriptor_issuer_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus();
    dma_descriptor_issuer #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .STATUS_BASE(64'h6000), .STATUS_STRIDE(64'h1000))
        dut (.clock(clock), .reset(reset), .bus(bus));

    logic [111:0] q [NUM_CH][$];
    push_t push_q[$];
    wr_t exp_q[$];
    int tests = 0, failed = 0, cyc = 0;
    logic [NUM_CH-1:0] pop_mask = '0;
    int stall_mode = 0, stall_cnt = 0;
    int m_last = NUM_CH - 1, earliest = 0, first_cyc = -1, errchk_cyc = -1, errchk_ch = 0;
    int mcount [NUM_CH];
    int write_cycles = 0, accepts = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit any_queued();
        for (int c = 0; c < NUM_CH; c++) if (q[c].size() > 0) return 1'b1;
        return push_q.size() > 0;
    endfunction

    function automatic logic [111:0] make_entry(logic [2:0] len, logic [31:0] hi, logic [31:0] lo);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r[107:105] = len;
        r[63:32] = hi;
        r[31:0] = lo;
        return r[111:0];
    endfunction

    function automatic logic [15:0] exp_cnt(int c);
        return STATS ? 16'(mcount[c]) : 16'd0;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // queue model drives the show-ahead heads; pops seen at the falling edge take effect after the rising edge
    initial begin
        push_t p;
        bus.QEmpty = '1;
        bus.QData = '0;
        bus.DcsWaitRequest = 1'b0;
        bus.DcsReadData = 32'hDEAD_BEEF;
        forever begin
            @(posedge clock);
            #1;
            for (int c = 0; c < NUM_CH; c++)
                if (pop_mask[c] && q[c].size() > 0) void'(q[c].pop_front());
            while (push_q.size() > 0) begin
                p = push_q.pop_front();
                q[p.ch].push_back(p.e);
            end
            if (stall_mode == 1)
                bus.DcsWaitRequest = ($urandom_range(0, 3) == 0);
            else if (stall_mode == 2 && bus.DcsWrite && bus.DcsAddress[4:2] == 3'd2 && stall_cnt < 3) begin
                bus.DcsWaitRequest = 1'b1;
                stall_cnt++;
            end else
                bus.DcsWaitRequest = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                bus.QEmpty[c] = (q[c].size() == 0);
                bus.QData[c*112 +: 112] = (q[c].size() > 0) ? q[c][0] : '0;
            end
        end
    end

    // monitor: predicts grants, timing and descriptor words from the queue contents
    initial begin
        int g;
        bit fnd;
        logic [111:0] e;
        logic [63:0] s;
        wr_t w;
        forever begin
            @(negedge clock);
            pop_mask = bus.QPop;
            if (reset) begin
                exp_q.delete();
                m_last = NUM_CH - 1;
                earliest = cyc + 1;
                first_cyc = -1;
                errchk_cyc = -1;
                for (int c = 0; c < NUM_CH; c++) mcount[c] = 0;
                continue;
            end
            if (bus.QPop != '0) begin
                g = m_last;
                fnd = 1'b0;
                for (int i = 1; i <= NUM_CH; i++)
                    if (!fnd && q[(m_last + i) % NUM_CH].size() > 0) begin
                        g = (m_last + i) % NUM_CH;
                        fnd = 1'b1;
                    end
                check("pop_from_nonempty", 64'(fnd), 64'd1);
                check("pop_grant", 64'(bus.QPop), 64'(1 << g));
                check("pop_not_early", 64'(cyc >= earliest), 64'd1);
                e = fnd ? q[g][0] : '0;
                m_last = g;
                if (e[107:105] == 3'd0) begin
                    check("drop_error_pulse", 64'(bus.DescError), 64'd1);
                    earliest = cyc + 2;
                    errchk_cyc = cyc + 1;
                    errchk_ch = g;
                end else begin
                    check("no_error_on_valid", 64'(bus.DescError), 64'd0);
                    s = 64'h6000 + 64'(g) * 64'h1000;
                    w.a = 8'(g * 32 + 0);  w.d = 32'(e[107:105]) - 32'd1; exp_q.push_back(w);
                    w.a = 8'(g * 32 + 4);  w.d = e[63:32];  exp_q.push_back(w);
                    w.a = 8'(g * 32 + 8);  w.d = e[31:0];   exp_q.push_back(w);
                    w.a = 8'(g * 32 + 12); w.d = s[63:32];  exp_q.push_back(w);
                    w.a = 8'(g * 32 + 16); w.d = s[31:0];   exp_q.push_back(w);
                    earliest = cyc + 7;
                    first_cyc = cyc + 1;
                end
            end else begin
                if (bus.DescError) check("spurious_error", 64'(bus.DescError), 64'd0);
                if (cyc == earliest && bus.QEmpty != '1) check("pop_when_idle", 64'(bus.QPop != '0), 64'd1);
            end
            if (cyc == errchk_cyc) check("error_channel", 64'(bus.DescErrorCh), 64'(errchk_ch));
            if (cyc == first_cyc) check("word0_latency", {60'd0, bus.DcsWrite, bus.DcsAddress[4:2]}, 64'h8);
            if (bus.DcsWrite) begin
                write_cycles++;
                check("dcs_strobes", {59'd0, bus.DcsChipSelect, bus.DcsByteEnable}, 64'h1F);
                if (bus.DcsWaitRequest)
                    earliest++;
                else if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_write: addr %0h data %0h, required no write", bus.DcsAddress, bus.DcsWriteData);
                end else begin
                    w = exp_q.pop_front();
                    accepts++;
                    check("dcs_addr", 64'(bus.DcsAddress), 64'(w.a));
                    check("dcs_data", 64'(bus.DcsWriteData), 64'(w.d));
                    if (w.a[4:2] == 3'd4) mcount[int'(w.a[5 +: CH_W])]++;
                end
            end else if (bus.DcsChipSelect || bus.DcsByteEnable != 4'h0)
                check("dcs_idle_strobes", {59'd0, bus.DcsChipSelect, bus.DcsByteEnable}, 64'h0);
        end
    end

    task automatic push(int ch, logic [111:0] e);
        push_t p;
        p.ch = ch;
        p.e = e;
        push_q.push_back(p);
    endtask

    task automatic drain();
        int n = 0;
        while ((any_queued() || exp_q.size() > 0 || bus.Busy) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        check("drain_in_time", 64'(n < 3000), 64'd1);
    endtask

    task automatic do_reset(int n);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_zero_outputs();
        check("rst_qpop", 64'(bus.QPop), 64'd0);
        check("rst_write", {62'd0, bus.DcsWrite, bus.DcsChipSelect}, 64'd0);
        check("rst_addr", 64'(bus.DcsAddress), 64'd0);
        check("rst_data", 64'(bus.DcsWriteData), 64'd0);
        check("rst_be", 64'(bus.DcsByteEnable), 64'd0);
        check("rst_read", 64'(bus.DcsRead), 64'd0);
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_error", {62'd0, bus.DescError, bus.DescErrorCh}, 64'd0);
        check("rst_issued", 64'(bus.IssuedCount), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero_outputs();
        @(posedge clock); #1;
        reset = 1'b0;

        push(0, make_entry(3'd3, 32'h1, 32'h2000));
        drain();

        for (int i = 0; i < 4; i++) begin
            push(0, make_entry(3'($urandom_range(1, 7)), $urandom, $urandom));
            push(1, make_entry(3'($urandom_range(1, 7)), $urandom, $urandom));
        end
        drain();

        stall_mode = 2;
        stall_cnt = 0;
        write_cycles = 0;
        accepts = 0;
        push(0, make_entry(3'd5, $urandom, $urandom));
        drain();
        check("stall_burst_cycles", 64'(write_cycles), 64'd8);
        check("stall_accepts", 64'(accepts), 64'd5);
        stall_mode = 0;

        accepts = 0;
        push(1, make_entry(3'd0, $urandom, $urandom));
        push(1, make_entry(3'd2, $urandom, $urandom));
        drain();
        check("drop_then_issue_accepts", 64'(accepts), 64'd5);
        check("error_channel_held", 64'(bus.DescErrorCh), 64'd1);

        stall_mode = 1;
        for (int i = 0; i < 150; i++) begin
            push($urandom_range(0, NUM_CH - 1), make_entry(3'($urandom_range(0, 7)), $urandom, $urandom));
            repeat ($urandom_range(0, 6)) @(posedge clock);
        end
        drain();
        for (int c = 0; c < NUM_CH; c++) check("issued_count_random", 64'(bus.IssuedCount[c*16 +: 16]), 64'(exp_cnt(c)));
        stall_mode = 0;

        do_reset(2);
        for (int i = 0; i < 3; i++) push(0, make_entry(3'd2, $urandom, $urandom));
        drain();
        check("issued_count_before_reset", 64'(bus.IssuedCount[15:0]), 64'(exp_cnt(0)));
        check("model_count_three", 64'(mcount[0]), 64'd3);

        push(0, make_entry(3'd4, $urandom, $urandom));
        n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (!(bus.DcsWrite && bus.DcsAddress[4:2] == 3'd3) && n < 100);
        check("reached_word3", 64'(n < 100), 64'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_zero_outputs();
        @(posedge clock); #1;
        reset = 1'b0;

        push(1, make_entry(3'd1, $urandom, $urandom));
        push(0, make_entry(3'd7, $urandom, $urandom));
        drain();
        for (int c = 0; c < NUM_CH; c++) check("issued_count_final", 64'(bus.IssuedCount[c*16 +: 16]), 64'(exp_cnt(c)));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
